ahb5_slave_mem: RTL

Synthesizable AHB5 memory slave that responds to the transfers issued by our AHB5 master agent. It replaces the dummy slave driver with a real responder for testbench and FPGA use. It decodes address and data phases, inserts a programmable number of wait states, and generates the two-cycle ERROR response. It stores data in an internal byte-lane-addressable word array.

---
 rtl/ahb5_pkg.sv | 45 ++++
 rtl/ahb5_slave_lane_mask.sv | 30 +++
 rtl/ahb5_slave_mem.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ahb5_pkg.sv
// ahb5_pkg: shared AHB5 encodings and slave-side types for the memory slave.
//   htrans_t      : transfer type encoding
//   HRESP_*       : response encodings
//   hsize_t       : transfer size encoding
//   slave_state_t : response FSM states
//   dphase_ctrl_t : registered data-phase control bundle
package ahb5_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_t;

  // Control captured at the address phase and held through the data phase.
  typedef struct packed {
    logic valid;
    logic write;
    logic err;
  } dphase_ctrl_t;

  // Largest legal HSIZE for a given data bus width.
  function automatic logic [2:0] max_hsize(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/ahb5_slave_lane_mask.sv
// ahb5_slave_lane_mask: byte-enable and alignment decode for one beat.
//   addr_lo   : in  low byte-offset bits of the address
//   size      : in  HSIZE (log2 bytes per beat)
//   be        : out one bit per byte lane touched by the beat
//   align_err : out address not aligned to the beat size
module ahb5_slave_lane_mask #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] addr_lo,
  input  logic [2:0]                      size,
  output logic [DATA_WIDTH/8-1:0]         be,
  output logic                            align_err
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  // Lanes from the byte offset up to offset+beat size are enabled.
  always_comb begin : mask_calc
    int unsigned lo;
    int unsigned span;
    lo        = 32'(addr_lo);
    span      = 32'(1) << size;
    be        = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      be[i] = (i >= lo) && (i < lo + span);
    end
    align_err = (lo & (span - 32'(1))) != 32'(0);
  end

endmodule

// File: rtl/ahb5_slave_mem.sv
// ahb5_slave_mem: AHB5 memory slave with programmable wait states and the
// two-cycle ERROR response, backed by a byte-lane-writable word array.
//   HCLK, HRESET          : clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HBURST : address phase (HBURST ignored)
//   HWDATA                : write data, data phase
//   HREADY                : bus ready in
//   HREADYOUT, HRESP      : registered handshake / response
//   HRDATA                : lane-gated read data of the current data phase
module ahb5_slave_mem
  import ahb5_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int unsigned NB         = DATA_WIDTH / 8;
  localparam int unsigned OW         = $clog2(NB);
  localparam int unsigned IW         = $clog2(MEM_DEPTH);
  localparam int unsigned BYTE_LIMIT = MEM_DEPTH * NB;
  localparam int unsigned CW         = 4;

  slave_state_t          state;
  logic [CW-1:0]         wait_cnt;
  logic                  ready_q;
  logic                  resp_q;
  dphase_ctrl_t          dp;
  logic [IW-1:0]         dp_word;
  logic [NB-1:0]         dp_be;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  htrans_t               trans_c;
  logic                  accept_c;
  logic [NB-1:0]         be_c;
  logic                  align_err_c;
  logic                  range_err_c;
  logic                  size_err_c;
  logic                  err_c;
  logic                  commit_c;
  logic [DATA_WIDTH-1:0] rdata_c;
  logic                  unused_hburst;

  assign unused_hburst = ^HBURST;

  // Address-phase decode.
  assign trans_c     = htrans_t'(HTRANS);
  assign accept_c    = HSEL && HREADY &&
                       ((trans_c == HTRANS_NONSEQ) || (trans_c == HTRANS_SEQ));
  assign range_err_c = HADDR >= ADDR_WIDTH'(BYTE_LIMIT);
  assign size_err_c  = HSIZE > max_hsize(DATA_WIDTH);
  assign err_c       = range_err_c || align_err_c || size_err_c;

  ahb5_slave_lane_mask #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_mask (
    .addr_lo   (HADDR[OW-1:0]),
    .size      (HSIZE),
    .be        (be_c),
    .align_err (align_err_c)
  );

  // Response FSM. Whenever HREADYOUT is high the current data phase ends on
  // this edge and a new address phase may be taken (covers IDLE, ERR2 and the
  // final ready cycle of WAIT).
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      ready_q  <= 1'b1;
      resp_q   <= HRESP_OKAY;
      dp       <= '0;
      dp_word  <= '0;
      dp_be    <= '0;
    end else if (ready_q) begin
      dp.valid <= accept_c;
      dp.write <= accept_c && HWRITE;
      dp.err   <= accept_c && err_c;
      dp_word  <= HADDR[OW +: IW];
      dp_be    <= be_c;
      if (accept_c && err_c) begin
        state   <= ST_ERR1;
        ready_q <= 1'b0;
        resp_q  <= HRESP_ERROR;
      end else if (accept_c && (WAIT_STATES != 0)) begin
        state    <= ST_WAIT;
        wait_cnt <= CW'(WAIT_STATES);
        ready_q  <= 1'b0;
        resp_q   <= HRESP_OKAY;
      end else begin
        state   <= ST_IDLE;
        ready_q <= 1'b1;
        resp_q  <= HRESP_OKAY;
      end
    end else if (state == ST_ERR1) begin
      state   <= ST_ERR2;
      ready_q <= 1'b1;
      resp_q  <= HRESP_ERROR;
    end else begin
      // WAIT countdown; ready rises in the cycle the counter reaches zero.
      wait_cnt <= wait_cnt - CW'(1);
      if (wait_cnt == CW'(1)) begin
        ready_q <= 1'b1;
      end
    end
  end

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;

  // Write lands on the edge that closes an OKAY write data phase.
  assign commit_c = ready_q && dp.valid && dp.write && !dp.err && !HRESET;

  always_ff @(posedge HCLK) begin
    if (commit_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (dp_be[i]) begin
          mem[dp_word][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Read data shows only the selected lanes of a valid, non-errored read.
  always_comb begin
    rdata_c = '0;
    if (dp.valid && !dp.write && !dp.err) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (dp_be[i]) begin
          rdata_c[8*i +: 8] = mem[dp_word][8*i +: 8];
        end
      end
    end
  end

  assign HRDATA = rdata_c;

endmodule
